// File: rtl/bram_port_arbiter.sv
// bram_port_arbiter: two-requester arbiter and two-stage sequencer for one
// port of a byte-write, read-first BRAM with 1-cycle registered read data.
// The winning command is registered, drives the RAM in the next cycle, and the
// RAM output is routed back to the issuing requester one cycle after that.
//
// Build option: define BRAM_ARB_ROUND_ROBIN_EN for round-robin arbitration
// with a MAX_BURST limit. Without it, requester 0 has fixed priority and
// MAX_BURST has no effect.
module bram_port_arbiter #(
    parameter int unsigned NUM_COL    = 4,
    parameter int unsigned COL_WIDTH  = 8,
    parameter int unsigned ADDR_WIDTH = 10,
    parameter int unsigned DATA_WIDTH = NUM_COL * COL_WIDTH,
    parameter int unsigned MAX_BURST  = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    // Requester side
    input  logic [1:0]              req_valid,
    output logic [1:0]              req_ready,
    input  logic [2*NUM_COL-1:0]    req_wen,
    input  logic [2*ADDR_WIDTH-1:0] req_addr,
    input  logic [2*DATA_WIDTH-1:0] req_wdata,
    output logic [1:0]              rsp_valid,
    output logic [DATA_WIDTH-1:0]   rsp_rdata,
    // RAM side
    output logic                    ram_en,
    output logic [NUM_COL-1:0]      ram_wen,
    output logic [ADDR_WIDTH-1:0]   ram_addr,
    output logic [DATA_WIDTH-1:0]   ram_din,
    input  logic [DATA_WIDTH-1:0]   ram_dout
);

    logic [1:0] grant;
    logic       xfer;
    logic       sel_id;

    // Ready is never raised while reset is asserted, so no transfer can occur.
    assign req_ready = rst ? 2'b00 : grant;
    assign xfer      = |req_ready;
    assign sel_id    = req_ready[1];

`ifdef BRAM_ARB_ROUND_ROBIN_EN
    localparam int unsigned CntW = $clog2(MAX_BURST + 1);
    localparam logic [CntW-1:0] MaxCnt = CntW'(MAX_BURST);

    logic            owner_q, owner_d;
    logic [CntW-1:0] burst_cnt_q, burst_cnt_d;
    logic            keep_owner;

    // A count of zero only exists straight after reset: the owner has not
    // actually been granted yet, so a tie goes to the other side (requester 0).
    assign keep_owner = (burst_cnt_q != '0) && (burst_cnt_q < MaxCnt);

    // Grant selection: round-robin with burst limit on ties.
    always_comb begin
        grant = 2'b00;
        unique case (req_valid)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11: begin
                if (keep_owner) grant = owner_q ? 2'b10 : 2'b01;
                else            grant = owner_q ? 2'b01 : 2'b10;
            end
            default: grant = 2'b00;
        endcase
    end

    // Owner/burst update on each transfer; saturating count for the owner.
    always_comb begin
        owner_d     = owner_q;
        burst_cnt_d = burst_cnt_q;
        if (xfer) begin
            if (sel_id == owner_q) begin
                if (burst_cnt_q != MaxCnt) burst_cnt_d = burst_cnt_q + 1'b1;
            end else begin
                owner_d     = sel_id;
                burst_cnt_d = CntW'(1);
            end
        end
    end

    // Arbiter state registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            owner_q     <= 1'b1;
            burst_cnt_q <= '0;
        end else begin
            owner_q     <= owner_d;
            burst_cnt_q <= burst_cnt_d;
        end
    end
`else
    // MAX_BURST has no role under fixed priority.
    logic unused_max_burst;
    assign unused_max_burst = (MAX_BURST == 0);

    // Grant selection: requester 0 always wins when valid.
    always_comb begin
        grant    = 2'b00;
        grant[0] = req_valid[0];
        grant[1] = req_valid[1] & ~req_valid[0];
    end
`endif

    // Command stage registers.
    logic                  cmd_vld_q, cmd_vld_d;
    logic                  cmd_id_q, cmd_id_d;
    logic [NUM_COL-1:0]    cmd_wen_q, cmd_wen_d;
    logic [ADDR_WIDTH-1:0] cmd_addr_q, cmd_addr_d;
    logic [DATA_WIDTH-1:0] cmd_wdata_q, cmd_wdata_d;

    // Response stage registers.
    logic rsp_vld_q, rsp_vld_d;
    logic rsp_id_q, rsp_id_d;

    logic [NUM_COL-1:0]    sel_wen;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [DATA_WIDTH-1:0] sel_wdata;

    // Payload of the granted requester.
    always_comb begin
        sel_wen   = sel_id ? req_wen[2*NUM_COL-1:NUM_COL]          : req_wen[NUM_COL-1:0];
        sel_addr  = sel_id ? req_addr[2*ADDR_WIDTH-1:ADDR_WIDTH]   : req_addr[ADDR_WIDTH-1:0];
        sel_wdata = sel_id ? req_wdata[2*DATA_WIDTH-1:DATA_WIDTH]  : req_wdata[DATA_WIDTH-1:0];
    end

    // Next state of both pipeline stages; address/data hold when idle.
    always_comb begin
        cmd_vld_d   = xfer;
        cmd_id_d    = sel_id;
        cmd_wen_d   = cmd_wen_q;
        cmd_addr_d  = cmd_addr_q;
        cmd_wdata_d = cmd_wdata_q;
        if (xfer) begin
            cmd_wen_d   = sel_wen;
            cmd_addr_d  = sel_addr;
            cmd_wdata_d = sel_wdata;
        end
        rsp_vld_d = cmd_vld_q;
        rsp_id_d  = cmd_id_q;
    end

    // Pipeline registers, cleared by reset so in-flight commands are dropped.
    always_ff @(posedge clk) begin
        if (rst) begin
            cmd_vld_q   <= 1'b0;
            cmd_id_q    <= 1'b0;
            cmd_wen_q   <= '0;
            cmd_addr_q  <= '0;
            cmd_wdata_q <= '0;
            rsp_vld_q   <= 1'b0;
            rsp_id_q    <= 1'b0;
        end else begin
            cmd_vld_q   <= cmd_vld_d;
            cmd_id_q    <= cmd_id_d;
            cmd_wen_q   <= cmd_wen_d;
            cmd_addr_q  <= cmd_addr_d;
            cmd_wdata_q <= cmd_wdata_d;
            rsp_vld_q   <= rsp_vld_d;
            rsp_id_q    <= rsp_id_d;
        end
    end

    logic rsp_fire;

    // RAM drive and response routing; gating with rst keeps a command that is
    // in flight when reset arrives from writing or responding.
    always_comb begin
        ram_en    = cmd_vld_q & ~rst;
        ram_wen   = ram_en ? cmd_wen_q : '0;
        ram_addr  = cmd_addr_q;
        ram_din   = cmd_wdata_q;
        rsp_fire  = rsp_vld_q & ~rst;
        rsp_valid = {rsp_fire & rsp_id_q, rsp_fire & ~rsp_id_q};
        rsp_rdata = rsp_fire ? ram_dout : '0;
    end

endmodule

// File: tb/tb_bram_port_arbiter.sv
// Directed bench for bram_port_arbiter with a behavioural read-first,
// byte-write BRAM attached to the RAM port.
module tb_bram_port_arbiter;

    logic        clk;
    logic        rst;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [7:0]  req_wen;
    logic [19:0] req_addr;
    logic [63:0] req_wdata;
    logic [1:0]  rsp_valid;
    logic [31:0] rsp_rdata;
    logic        ram_en;
    logic [3:0]  ram_wen;
    logic [9:0]  ram_addr;
    logic [31:0] ram_din;
    logic [31:0] ram_dout;

    int checks_n = 0;
    int fail_n   = 0;

    bram_port_arbiter #(
        .NUM_COL   (4),
        .COL_WIDTH (8),
        .ADDR_WIDTH(10),
        .MAX_BURST (2)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_wen  (req_wen),
        .req_addr (req_addr),
        .req_wdata(req_wdata),
        .rsp_valid(rsp_valid),
        .rsp_rdata(rsp_rdata),
        .ram_en   (ram_en),
        .ram_wen  (ram_wen),
        .ram_addr (ram_addr),
        .ram_din  (ram_din),
        .ram_dout (ram_dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural RAM: read-first, byte writes, registered dout, plus preload.
    logic [31:0] mem [1024];
    logic        preload_en;
    logic [9:0]  preload_addr;
    logic [31:0] preload_data;

    always @(posedge clk) begin
        if (preload_en) mem[preload_addr] <= preload_data;
        if (ram_en) begin
            ram_dout <= mem[ram_addr];
            for (int b = 0; b < 4; b++)
                if (ram_wen[b]) mem[ram_addr][b*8 +: 8] <= ram_din[b*8 +: 8];
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks_n++;
        if (got !== exp) begin
            fail_n++;
            $display("FAIL %s got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic preload(input logic [9:0] a, input logic [31:0] d);
        preload_addr = a;
        preload_data = d;
        preload_en   = 1'b1;
        cyc();
        preload_en   = 1'b0;
    endtask

    task automatic drive(input int id, input logic [3:0] wen, input logic [9:0] a,
                         input logic [31:0] d);
        req_valid[id]         = 1'b1;
        req_wen[id*4 +: 4]    = wen;
        req_addr[id*10 +: 10] = a;
        req_wdata[id*32 +: 32] = d;
    endtask

    int          eg [6];
    logic [31:0] ed [6];
    int          k0;
    int          k1;

    initial begin
`ifdef BRAM_ARB_ROUND_ROBIN_EN
        eg = '{0, 0, 1, 1, 0, 0};
`else
        eg = '{0, 0, 0, 0, 0, 0};
`endif
        rst = 1'b1;
        req_valid = 2'b00;
        req_wen = '0;
        req_addr = '0;
        req_wdata = '0;
        preload_en = 1'b0;
        preload_addr = '0;
        preload_data = '0;
        cyc();
        preload(10'd5, 32'hDEADBEEF);
        preload(10'd7, 32'hCAFEF00D);
        preload(10'd31, 32'h31313131);
        for (int i = 0; i < 6; i++) begin
            preload(10'(20 + i), 32'h1000 + 32'(i));
            preload(10'(40 + i), 32'h2000 + 32'(i));
        end

        // Reset behaviour
        req_valid = 2'b11;
        @(negedge clk);
        check("ready_in_rst", 32'(req_ready), 32'h0);
        req_valid = 2'b00;
        cyc();
        rst = 1'b0;
        @(negedge clk);
        check("rst_rsp_valid", 32'(rsp_valid), 32'h0);
        check("rst_rsp_rdata", rsp_rdata, 32'h0);
        check("rst_ram_en", 32'(ram_en), 32'h0);
        check("rst_ram_wen", 32'(ram_wen), 32'h0);
        check("rst_ram_addr", 32'(ram_addr), 32'h0);
        check("rst_ram_din", ram_din, 32'h0);

        // Requester 0 reads addr 5
        cyc();
        drive(0, 4'b0000, 10'd5, 32'h0);
        @(negedge clk);
        check("t1_ready", 32'(req_ready), 32'h1);
        cyc();
        req_valid = 2'b00;
        @(negedge clk);
        check("t1_ram_en", 32'(ram_en), 32'h1);
        check("t1_ram_addr", 32'(ram_addr), 32'd5);
        check("t1_ram_wen", 32'(ram_wen), 32'h0);
        check("t1_early_rsp", 32'(rsp_valid), 32'h0);
        cyc();
        @(negedge clk);
        check("t1_rsp_valid", 32'(rsp_valid), 32'h1);
        check("t1_rsp_rdata", rsp_rdata, 32'hDEADBEEF);
        cyc();
        @(negedge clk);
        check("t1_rsp_once", 32'(rsp_valid), 32'h0);
        check("t1_ram_idle", 32'(ram_en), 32'h0);

        // Requester 1 byte-writes addr 5, then requester 0 reads it back
        cyc();
        drive(1, 4'b0010, 10'd5, 32'h0000AB00);
        @(negedge clk);
        check("t2_ready", 32'(req_ready), 32'h2);
        cyc();
        req_valid = 2'b00;
        @(negedge clk);
        check("t2_ram_wen", 32'(ram_wen), 32'h2);
        check("t2_ram_din", ram_din, 32'h0000AB00);
        cyc();
        @(negedge clk);
        check("t2_wr_rsp_valid", 32'(rsp_valid), 32'h2);
        check("t2_wr_rsp_old", rsp_rdata, 32'hDEADBEEF);
        cyc();
        drive(0, 4'b0000, 10'd5, 32'h0);
        @(negedge clk);
        check("t2_rd_ready", 32'(req_ready), 32'h1);
        cyc();
        req_valid = 2'b00;
        cyc();
        @(negedge clk);
        check("t2_rd_rsp_valid", 32'(rsp_valid), 32'h1);
        check("t2_rd_rsp_new", rsp_rdata, 32'hDEADABEF);

        // Read-after-write, back-to-back accepts on addr 7
        cyc();
        drive(0, 4'b1111, 10'd7, 32'h12345678);
        @(negedge clk);
        check("t3_wr_ready", 32'(req_ready), 32'h1);
        cyc();
        req_valid = 2'b00;
        drive(1, 4'b0000, 10'd7, 32'h0);
        @(negedge clk);
        check("t3_rd_ready", 32'(req_ready), 32'h2);
        check("t3_ram_wen", 32'(ram_wen), 32'hF);
        cyc();
        req_valid = 2'b00;
        @(negedge clk);
        check("t3_rsp0_valid", 32'(rsp_valid), 32'h1);
        check("t3_rsp0_old", rsp_rdata, 32'hCAFEF00D);
        cyc();
        @(negedge clk);
        check("t3_rsp1_valid", 32'(rsp_valid), 32'h2);
        check("t3_rsp1_new", rsp_rdata, 32'h12345678);

        // Reset with two commands in flight
        cyc();
        drive(0, 4'b1111, 10'd30, 32'h55555555);
        @(negedge clk);
        check("t5_a_ready", 32'(req_ready), 32'h1);
        cyc();
        req_valid = 2'b00;
        drive(1, 4'b1111, 10'd31, 32'hAAAAAAAA);
        @(negedge clk);
        check("t5_b_ready", 32'(req_ready), 32'h2);
        cyc();
        req_valid = 2'b00;
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        @(negedge clk);
        check("t5_ram_en", 32'(ram_en), 32'h0);
        check("t5_ram_wen", 32'(ram_wen), 32'h0);
        check("t5_rsp_valid", 32'(rsp_valid), 32'h0);
        check("t5_mem30_written", mem[30], 32'h55555555);
        check("t5_mem31_dropped", mem[31], 32'h31313131);

        // Both requesters valid every cycle, starting from reset state
        k0 = 0;
        k1 = 0;
        for (int c = 0; c < 9; c++) begin
            cyc();
            if (c < 6) begin
                req_valid = 2'b11;
                drive(0, 4'b0000, 10'(20 + k0), 32'h0);
                drive(1, 4'b0000, 10'(40 + k1), 32'h0);
            end else begin
                req_valid = 2'b00;
            end
            @(negedge clk);
            if (c < 6) begin
                check($sformatf("t4_ready_c%0d", c), 32'(req_ready),
                      (eg[c] == 1) ? 32'h2 : 32'h1);
                ed[c] = (eg[c] == 1) ? 32'h2000 + 32'(k1) : 32'h1000 + 32'(k0);
                if (eg[c] == 1) k1++;
                else            k0++;
            end
            if (c >= 2 && c < 8) begin
                check($sformatf("t4_rsp_valid_c%0d", c), 32'(rsp_valid),
                      (eg[c-2] == 1) ? 32'h2 : 32'h1);
                check($sformatf("t4_rsp_rdata_c%0d", c), rsp_rdata, ed[c-2]);
            end else begin
                check($sformatf("t4_rsp_idle_c%0d", c), 32'(rsp_valid), 32'h0);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks_n, fail_n);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
